dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's load/store path; it answers requests issued by the memory stage.
- Holds a word-organised data RAM and applies a configurable number of wait states to every access.
- Supports byte, halfword and word accesses, with sign or zero extension on loads.
- Uses a single-outstanding valid/ready request/response handshake; a stall output freezes the pipeline while an access is in flight.

---
 rtl/dmem_responder_pkg.sv | 29 ++
 rtl/dmem_responder_ram_bw.sv | 27 ++
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Access-size codes, FSM states and the alignment rule.
package dmem_responder_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        unique case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_ram_bw.sv
// Word-organised RAM with per-byte write enables.
// Synchronous write, combinational read, no reset.
module dmem_ram_bw #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write each enabled byte lane of the addressed word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: single outstanding request, fixed wait states.
// Byte/half/word access with sign or zero extension on loads.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic NOWAIT = (WAIT_CYCLES == 0);

    state_t        r_state;
    state_t        w_next;
    logic          r_we;
    logic          r_uns;
    logic [1:0]    r_size;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_idle;
    logic          w_accept;
    logic          w_acc_err;
    logic          w_commit;
    logic          w_we;
    logic          w_uns;
    logic [1:0]    w_size;
    logic [AW+1:0] w_addr;
    logic [1:0]    w_lo;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;
    logic [31:0]   w_ram_rdata;
    logic          w_unused;

    assign w_unused  = ^req_addr[31:AW+2];

    assign w_idle    = (r_state == S_IDLE);
    assign req_ready = rst & w_idle;
    assign rsp_valid = (r_state == S_RESP);
    assign stall     = ~w_idle;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept  = req_valid & req_ready;
    assign w_acc_err = misaligned(req_size, req_addr[1:0]);

    // With no wait states the access uses the live request fields.
    assign w_we    = w_idle ? req_we            : r_we;
    assign w_uns   = w_idle ? req_unsigned      : r_uns;
    assign w_size  = w_idle ? req_size          : r_size;
    assign w_addr  = w_idle ? req_addr[AW+1:0]  : r_addr;
    assign w_wdata = w_idle ? req_wdata         : r_wdata;
    assign w_lo    = w_addr[1:0];

    assign w_commit =
        ((r_state == S_BUSY) && (r_cnt == '0)) ||
        (w_accept && !w_acc_err && NOWAIT);

    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lo,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        unique case (1'b1)
            (size == SZ_B): res = {{24{b[7] & ~uns}}, b};
            (size == SZ_H): res = {{16{h[15] & ~uns}}, h};
            default:        res = word;
        endcase
        return res;
    endfunction

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = w_wdata;
        unique case (1'b1)
            (w_size == SZ_B): begin
                w_be    = 4'b0001 << w_lo;
                w_wlane = {4{w_wdata[7:0]}};
            end
            (w_size == SZ_H): begin
                w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
            end
        endcase
    end

    dmem_ram_bw #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    ((w_commit && w_we) ? w_be : 4'b0000),
        .i_addr  (w_addr[AW+1:2]),
        .i_wdata (w_wlane),
        .o_rdata (w_ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: errors and no-wait accesses skip BUSY.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_acc_err || NOWAIT) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, wait counter and response data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_B;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_size  <= req_size;
                r_addr  <= req_addr[AW+1:0];
                r_wdata <= req_wdata;
                r_cnt   <= CNT_INIT;
                r_err   <= w_acc_err;
                r_rdata <= '0;
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit && !w_we) begin
                r_rdata <= extract(w_ram_rdata, w_size, w_lo, w_uns);
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances,
// each with a byte-array reference model and a response scoreboard.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit done0 = 0;
    bit done1 = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        longint      t;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int WC = (g == 0) ? 2 : 0;

        logic        rst, req_valid, req_ready, req_we, req_unsigned;
        logic        rsp_valid, rsp_ready, rsp_err, stall;
        logic [1:0]  req_size;
        logic [31:0] req_addr, req_wdata, rsp_rdata;

        exp_t        q[$];
        logic [7:0]  m[int];
        bit          prev_v = 0;
        bit          b2b = 0;
        bit          rnd = 0;
        longint      last_t = 0;
        logic [31:0] prev_d;
        logic        prev_e;

        dmem_responder #(
            .DEPTH       (1024),
            .WAIT_CYCLES (WC)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid),
            .req_ready    (req_ready),
            .req_we       (req_we),
            .req_size     (req_size),
            .req_unsigned (req_unsigned),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .rsp_valid    (rsp_valid),
            .rsp_ready    (rsp_ready),
            .rsp_rdata    (rsp_rdata),
            .rsp_err      (rsp_err),
            .stall        (stall)
        );

        // Monitor: pop on a fresh response, check stability while held.
        always @(posedge clk) begin
            exp_t e;
            #1;
            if (rsp_valid === 1'b1 && !prev_v) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL i%0d unexpected rsp: got %h want none",
                             g, rsp_rdata);
                end else begin
                    e = q.pop_front();
                    check($sformatf("i%0d rdata", g), rsp_rdata, e.rdata);
                    check($sformatf("i%0d err", g), 32'(rsp_err), 32'(e.err));
                    check($sformatf("i%0d latency", g),
                          32'(($time - 1 - e.t) / 10 + 1), 32'(e.lat));
                    if (b2b && last_t != 0)
                        check($sformatf("i%0d b2b gap", g),
                              32'($time - last_t), 32'((WC + 2) * 10));
                end
                last_t = $time;
            end else if (rsp_valid === 1'b1) begin
                check($sformatf("i%0d hold rdata", g), rsp_rdata, prev_d);
                check($sformatf("i%0d hold err", g), 32'(rsp_err), 32'(prev_e));
                check($sformatf("i%0d hold stall", g), 32'(stall), 32'd1);
                check($sformatf("i%0d hold req_ready", g),
                      32'(req_ready), 32'd0);
            end
            prev_v = (rsp_valid === 1'b1);
            prev_d = rsp_rdata;
            prev_e = rsp_err;
        end

        // Random response backpressure during the random phase.
        always @(negedge clk) begin
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
        end

        task automatic issue(input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a,
                             input logic [31:0] wd, input bit upd = 1,
                             input bit push = 1);
            exp_t        e;
            int          n;
            int          k;
            int          nb;
            logic [31:0] v;
            n = 0;
            @(negedge clk);
            while (req_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (req_ready !== 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL i%0d issue timeout: got ready=%b want 1",
                         g, req_ready);
                return;
            end
            req_we       = we;
            req_size     = sz;
            req_unsigned = uns;
            req_addr     = a;
            req_wdata    = wd;
            req_valid    = 1'b1;
            e.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                    (sz == 2'b10 && a[1:0] != 2'b00);
            e.rdata = '0;
            e.t     = $time + 5;
            e.lat   = (e.err || WC == 0) ? 1 : WC + 1;
            if (!e.err) begin
                nb = 1 << sz;
                k  = int'(a[11:0]);
                if (we) begin
                    if (upd)
                        for (int i = 0; i < nb; i++) m[k + i] = wd[8*i +: 8];
                end else begin
                    v = '0;
                    for (int i = 0; i < nb; i++)
                        v[8*i +: 8] = m.exists(k + i) ? m[k + i] : 8'hxx;
                    if (!uns && v[8*nb - 1])
                        for (int i = 8 * nb; i < 32; i++) v[i] = 1'b1;
                    e.rdata = v;
                end
            end
            if (push) q.push_back(e);
            @(posedge clk);
            #1 req_valid = 1'b0;
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((q.size() != 0 || rsp_valid !== 1'b0 || stall !== 1'b0)
                   && n < 200) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("i%0d drain pending", g), 32'(q.size()), 32'd0);
        endtask

        initial begin
            logic [31:0] up;
            int          n;
            rst = 1'b1;
            req_valid = 1'b0;
            req_we = 1'b0;
            req_size = SZ_B;
            req_unsigned = 1'b0;
            req_addr = '0;
            req_wdata = '0;
            rsp_ready = 1'b1;
            #2 rst = 1'b0;
            repeat (3) @(negedge clk);
            check($sformatf("i%0d rst req_ready", g), 32'(req_ready), 32'd0);
            check($sformatf("i%0d rst rsp_valid", g), 32'(rsp_valid), 32'd0);
            check($sformatf("i%0d rst rsp_rdata", g), rsp_rdata, 32'd0);
            check($sformatf("i%0d rst rsp_err", g), 32'(rsp_err), 32'd0);
            check($sformatf("i%0d rst stall", g), 32'(stall), 32'd0);
            rst = 1'b1;
            @(posedge clk);
            #1 check($sformatf("i%0d idle ready", g), 32'(req_ready), 32'd1);

            issue(1, SZ_W, 0, 32'h40, 32'hDEADBEEF);
            issue(0, SZ_W, 0, 32'h40, 0);
            issue(1, SZ_B, 0, 32'h41, 32'h80);
            issue(0, SZ_W, 0, 32'h40, 0);
            issue(0, SZ_B, 0, 32'h41, 0);
            issue(0, SZ_B, 1, 32'h41, 0);
            issue(0, SZ_H, 0, 32'h42, 0);
            issue(1, SZ_W, 0, 32'h42, 32'h11111111);
            issue(0, SZ_W, 0, 32'h40, 0);
            issue(0, SZ_H, 0, 32'h43, 0);
            issue(1, 2'b11, 0, 32'h44, 32'h5);
            drain();

            rsp_ready = 1'b0;
            issue(0, SZ_W, 0, 32'h40, 0);
            n = 0;
            while (rsp_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("i%0d bp valid", g), 32'(rsp_valid), 32'd1);
            repeat (5) @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("i%0d bp release valid", g),
                  32'(rsp_valid), 32'd0);
            check($sformatf("i%0d bp release stall", g), 32'(stall), 32'd0);
            check($sformatf("i%0d bp release ready", g),
                  32'(req_ready), 32'd1);

            last_t = 0;
            b2b = 1;
            issue(1, SZ_W, 0, 32'h1000, 32'h12345678);
            issue(0, SZ_W, 0, 32'h0, 0);
            issue(0, SZ_H, 1, 32'h2, 0);
            issue(1, SZ_B, 0, 32'hFFFF_F003, 32'hA5);
            issue(0, SZ_W, 0, 32'h0, 0);
            drain();
            b2b = 0;

            issue(1, SZ_W, 0, 32'h80, 32'hCAFEF00D);
            drain();
            issue(1, SZ_W, 0, 32'h80, 32'h0BADBEEF, WC == 0, WC == 0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check($sformatf("i%0d midrst req_ready", g), 32'(req_ready), 32'd0);
            check($sformatf("i%0d midrst rsp_valid", g), 32'(rsp_valid), 32'd0);
            check($sformatf("i%0d midrst rsp_rdata", g), rsp_rdata, 32'd0);
            check($sformatf("i%0d midrst rsp_err", g), 32'(rsp_err), 32'd0);
            check($sformatf("i%0d midrst stall", g), 32'(stall), 32'd0);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1 check($sformatf("i%0d post rst ready", g),
                     32'(req_ready), 32'd1);
            issue(0, SZ_W, 0, 32'h80, 0);
            drain();

            for (int w = 0; w < 16; w++) begin
                up = $urandom & 32'hFFFF_F000;
                issue(1, SZ_W, 0, up | 32'h100 | 32'(w * 4), $urandom);
            end
            rnd = 1;
            for (int i = 0; i < 150; i++) begin
                up = $urandom & 32'hFFFF_F000;
                issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)),
                      up | 32'h100 | 32'($urandom_range(0, 63)), $urandom);
            end
            rnd = 0;
            rsp_ready = 1'b1;
            drain();
            if (g == 0) done0 = 1;
            else done1 = 1;
        end
    end

    initial begin
        wait (done0 && done1);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
